// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the default
// bit-period divisor, used by both the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Clocks per bit for a given clock (MHz) and baud; clamped to the 2-cycle
  // minimum so the bit counter always has a terminal count above zero.
  function automatic int unsigned default_div(input int unsigned clk_mhz,
                                              input int unsigned baud);
    int unsigned d;
    d = (clk_mhz * 1000000) / baud;
    if (d < 2) d = 2;
    return d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read, so the consumer
// can latch the head word in the same cycle it pops.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_push,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_pop,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_reg == (AW+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign out_data = mem[rd_ptr_reg];

  // A push is refused while full even if a pop happens in the same cycle.
  assign do_push = in_push && !full;
  assign do_pop  = in_pop && !empty;

  always_ff @(posedge in_clk) begin
    if (do_push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with per-frame configurable divisor, data parity
// and stop-bit count; frames stream back-to-back while words are queued.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_RATE_MHz = 100,
  parameter int BAUDRATE     = 9600,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                            in_clk,
  input  logic                            in_rst_n,
  input  logic                            in_en,
  input  logic [DIV_WIDTH-1:0]            in_cfg_div,
  input  logic [1:0]                      in_cfg_parity,
  input  logic                            in_cfg_stop2,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_ready,
  output logic                            out_txd,
  output logic                            out_busy,
  output logic [$clog2(FIFO_DEPTH):0]     out_fifo_level
);

  localparam int unsigned          DEF_DIV   = default_div(CLK_RATE_MHz, BAUDRATE);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV_W = DIV_WIDTH'(DEF_DIV);
  localparam int                   IDX_W     = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

  uart_state_t            state_reg,    state_next;
  logic [DIV_WIDTH-1:0]   bit_cnt_reg,  bit_cnt_next;
  logic [DIV_WIDTH-1:0]   div_reg,      div_next;
  logic [DATA_WIDTH-1:0]  shift_reg,    shift_next;
  logic [IDX_W-1:0]       idx_reg,      idx_next;
  logic                   par_acc_reg,  par_acc_next;
  logic                   par_en_reg,   par_en_next;
  logic                   stop2_reg,    stop2_next;
  logic                   stop_idx_reg, stop_idx_next;
  logic                   txd_reg,      txd_next;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [DATA_WIDTH-1:0]  fifo_data;
  logic [DIV_WIDTH-1:0]   cfg_div_eff;
  logic                   last_cnt;
  logic                   load_frame;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_push  (in_valid),
    .in_data  (in_data),
    .in_pop   (fifo_pop),
    .out_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (out_fifo_level)
  );

  assign out_ready = !fifo_full;
  assign out_txd   = txd_reg;
  assign out_busy  = (state_reg != ST_IDLE);
  assign last_cnt  = (bit_cnt_reg == div_reg - 1'b1);

  // Divisor 0 means "use the build-time default"; 1 is too short to count.
  always_comb begin
    cfg_div_eff = in_cfg_div;
    if (in_cfg_div == '0)
      cfg_div_eff = DEF_DIV_W;
    else if (in_cfg_div == DIV_WIDTH'(1))
      cfg_div_eff = DIV_WIDTH'(2);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      div_reg      <= '0;
      shift_reg    <= '0;
      idx_reg      <= '0;
      par_acc_reg  <= 1'b0;
      par_en_reg   <= 1'b0;
      stop2_reg    <= 1'b0;
      stop_idx_reg <= 1'b0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      div_reg      <= div_next;
      shift_reg    <= shift_next;
      idx_reg      <= idx_next;
      par_acc_reg  <= par_acc_next;
      par_en_reg   <= par_en_next;
      stop2_reg    <= stop2_next;
      stop_idx_reg <= stop_idx_next;
      txd_reg      <= txd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    div_next      = div_reg;
    shift_next    = shift_reg;
    idx_next      = idx_reg;
    par_acc_next  = par_acc_reg;
    par_en_next   = par_en_reg;
    stop2_next    = stop2_reg;
    stop_idx_next = stop_idx_reg;
    txd_next      = txd_reg;
    load_frame    = 1'b0;

    if (in_en && state_reg != ST_IDLE)
      bit_cnt_next = last_cnt ? '0 : bit_cnt_reg + 1'b1;

    unique case (state_reg)
      ST_IDLE: begin
        txd_next = 1'b1;
        if (in_en && !fifo_empty) load_frame = 1'b1;
      end

      ST_START: begin
        if (in_en && last_cnt) begin
          txd_next     = shift_reg[0];
          shift_next   = shift_reg >> 1;
          par_acc_next = par_acc_reg ^ shift_reg[0];
          idx_next     = '0;
          state_next   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (in_en && last_cnt) begin
          if (idx_reg == LAST_IDX) begin
            stop_idx_next = 1'b0;
            if (par_en_reg) begin
              txd_next   = par_acc_reg;
              state_next = ST_PARITY;
            end else begin
              txd_next   = 1'b1;
              state_next = ST_STOP;
            end
          end else begin
            txd_next     = shift_reg[0];
            shift_next   = shift_reg >> 1;
            par_acc_next = par_acc_reg ^ shift_reg[0];
            idx_next     = idx_reg + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (in_en && last_cnt) begin
          txd_next      = 1'b1;
          stop_idx_next = 1'b0;
          state_next    = ST_STOP;
        end
      end

      ST_STOP: begin
        if (in_en && last_cnt) begin
          if (stop2_reg && !stop_idx_reg)
            stop_idx_next = 1'b1;
          else if (!fifo_empty)
            load_frame = 1'b1;
          else
            state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    fifo_pop = load_frame;

    // Configuration is captured only here so mid-frame changes wait for the
    // next word; the parity accumulator is seeded with 1 for odd parity.
    if (load_frame) begin
      shift_next   = fifo_data;
      div_next     = cfg_div_eff;
      par_en_next  = (in_cfg_parity == PAR_EVEN) || (in_cfg_parity == PAR_ODD);
      par_acc_next = (in_cfg_parity == PAR_ODD);
      stop2_next   = in_cfg_stop2;
      txd_next     = 1'b0;
      bit_cnt_next = '0;
      state_next   = ST_START;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench: frame-level line model checked every cycle, plus
// literal per-scenario expectations for frame lengths and bit patterns.
module tb_uart_tx_cfg;

  localparam int CLK_MHZ    = 1;
  localparam int BAUD       = 100000;
  localparam int DW         = 8;
  localparam int DEPTH      = 4;
  localparam int DIVW       = 16;
  localparam int DEF_DIV_TB = 10;  // 1 MHz / 100 kBd

  logic            in_clk;
  logic            in_rst_n;
  logic            in_en;
  logic [DIVW-1:0] in_cfg_div;
  logic [1:0]      in_cfg_parity;
  logic            in_cfg_stop2;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            out_ready;
  logic            out_txd;
  logic            out_busy;
  logic [$clog2(DEPTH):0] out_fifo_level;

  int checks   = 0;
  int failures = 0;

  uart_tx_cfg #(
    .CLK_RATE_MHz (CLK_MHZ),
    .BAUDRATE     (BAUD),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .DIV_WIDTH    (DIVW)
  ) dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .in_en          (in_en),
    .in_cfg_div     (in_cfg_div),
    .in_cfg_parity  (in_cfg_parity),
    .in_cfg_stop2   (in_cfg_stop2),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_ready      (out_ready),
    .out_txd        (out_txd),
    .out_busy       (out_busy),
    .out_fifo_level (out_fifo_level)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: a queue of words and the bit list of the frame on the wire.
  int m_q[$];
  bit m_active = 1'b0;
  int m_bit    = 0;
  int m_cyc    = 0;
  int m_div    = 2;
  int m_nbits  = 0;
  bit m_bits [16];

  task automatic build_frame(input int word);
    int n;
    int ones;
    n = 0;
    ones = 0;
    m_div = (in_cfg_div == 0) ? DEF_DIV_TB : (in_cfg_div == 1) ? 2 : int'(in_cfg_div);
    m_bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < DW; i++) begin
      m_bits[n] = ((word >> i) & 1) != 0;
      ones = ones + ((word >> i) & 1);
      n = n + 1;
    end
    if (in_cfg_parity == 2'b01) begin m_bits[n] = (ones % 2) == 1; n = n + 1; end
    if (in_cfg_parity == 2'b10) begin m_bits[n] = (ones % 2) == 0; n = n + 1; end
    m_bits[n] = 1'b1; n = n + 1;
    if (in_cfg_stop2) begin m_bits[n] = 1'b1; n = n + 1; end
    m_nbits  = n;
    m_active = 1'b1;
    m_bit    = 0;
    m_cyc    = 0;
  endtask

  always @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_bit    = 0;
      m_cyc    = 0;
    end else begin
      bit ready_pre;
      ready_pre = (m_q.size() < DEPTH);
      if (in_en) begin
        if (m_active) begin
          m_cyc++;
          if (m_cyc == m_div) begin
            m_cyc = 0;
            m_bit++;
            if (m_bit == m_nbits) m_active = 1'b0;
          end
        end
        if (!m_active && m_q.size() > 0) build_frame(m_q.pop_front());
      end
      if (in_valid && ready_pre) m_q.push_back(int'(in_data));
      #1;
      if (in_rst_n) begin
        check("model_txd",   int'(out_txd),        m_active ? int'(m_bits[m_bit]) : 1);
        check("model_busy",  int'(out_busy),       int'(m_active));
        check("model_level", int'(out_fifo_level), m_q.size());
        check("model_ready", int'(out_ready),      int'(m_q.size() < DEPTH));
      end
    end
  end

  task automatic push_burst(input int n, input int base);
    @(negedge in_clk);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = DW'(base + i);
      @(negedge in_clk);
    end
    in_valid = 1'b0;
  endtask

  // Waits for the frame(s) to start, then counts busy cycles and samples the
  // line mid-bit; optionally retunes the divisor or pauses in_en on the way.
  task automatic measure(input int div, input int chg_at, input int new_div,
                         input int hold_at, input int hold_len,
                         output int wait_cyc, output int len, output logic [15:0] bits);
    wait_cyc = 0;
    len      = 0;
    bits     = '0;
    @(posedge in_clk); #1;
    while (!out_busy && wait_cyc < 100) begin
      wait_cyc++;
      @(posedge in_clk); #1;
    end
    if (!out_busy) check("busy_start_timeout", 0, 1);
    while (out_busy && len < 5000) begin
      if (len == chg_at) in_cfg_div = DIVW'(new_div);
      if (len == hold_at) in_en = 1'b0;
      if (len == hold_at + hold_len) in_en = 1'b1;
      if ((len % div) == (div / 2) && (len / div) < 16) bits[len / div] = out_txd;
      len++;
      @(posedge in_clk); #1;
    end
  endtask

  initial begin
    int wc;
    int len;
    int cnt;
    logic [15:0] bits;

    in_rst_n = 1'b0; in_en = 1'b0; in_cfg_div = 16; in_cfg_parity = 2'b00;
    in_cfg_stop2 = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge in_clk);
    check("rst_txd",   int'(out_txd),        1);
    check("rst_busy",  int'(out_busy),       0);
    check("rst_ready", int'(out_ready),      1);
    check("rst_level", int'(out_fifo_level), 0);
    in_rst_n = 1'b1;
    in_en    = 1'b1;

    // 8N1, div 16, 0xA5
    push_burst(1, 8'hA5);
    measure(16, -1, 0, -1, 0, wc, len, bits);
    $display("frame 8N1 word=a5 wait=%0d busy_cycles=%0d bits=%b", wc, len, bits[9:0]);
    check("8n1_latency", wc, 0);
    check("8n1_len", len, 160);
    check("8n1_bits", int'(bits[9:0]), int'(10'b1101001010));

    // 8E2, 0x07
    in_cfg_parity = 2'b01; in_cfg_stop2 = 1'b1;
    push_burst(1, 8'h07);
    measure(16, -1, 0, -1, 0, wc, len, bits);
    $display("frame 8E2 word=07 busy_cycles=%0d bits=%b", len, bits[11:0]);
    check("8e2_len", len, 192);
    check("8e2_bits", int'(bits[11:0]), int'(12'hE0E));

    // 8O1, 0x07
    in_cfg_parity = 2'b10; in_cfg_stop2 = 1'b0;
    push_burst(1, 8'h07);
    measure(16, -1, 0, -1, 0, wc, len, bits);
    $display("frame 8O1 word=07 busy_cycles=%0d bits=%b", len, bits[10:0]);
    check("8o1_len", len, 176);
    check("8o1_bits", int'(bits[10:0]), int'(11'h40E));

    // Fill with transmitter disabled: fifth word refused
    in_cfg_parity = 2'b00; in_en = 1'b0;
    push_burst(5, 8'h11);
    $display("burst of 5 with en=0 ready=%0d level=%0d", out_ready, out_fifo_level);
    check("full_ready", int'(out_ready), 0);
    check("full_level", int'(out_fifo_level), 4);
    in_en = 1'b1;
    measure(16, -1, 0, -1, 0, wc, len, bits);
    $display("four back-to-back frames busy_cycles=%0d", len);
    check("b2b_len", len, 640);

    // en paused mid-frame stretches it by the paused cycles
    push_burst(1, 8'h3C);
    measure(16, -1, 0, 50, 7, wc, len, bits);
    $display("frame 8N1 word=3c en-hold=7 busy_cycles=%0d", len);
    check("hold_len", len, 167);

    // Divisor change mid-frame affects only the next frame
    in_en = 1'b0;
    push_burst(2, 8'h81);
    in_en = 1'b1;
    measure(16, 40, 8, -1, 0, wc, len, bits);
    $display("frames 81,82 div 16->8 busy_cycles=%0d", len);
    check("divchg_len", len, 240);

    // Reset during data bit 3 with two words queued
    in_cfg_div = 16;
    in_en = 1'b0;
    push_burst(3, 8'h5A);
    in_en = 1'b1;
    cnt = 0;
    @(posedge in_clk); #1;
    while (out_busy && cnt < 72) begin
      cnt++;
      @(posedge in_clk); #1;
    end
    check("pre_rst_level", int'(out_fifo_level), 2);
    @(negedge in_clk);
    in_rst_n = 1'b0;
    #1;
    $display("reset mid-frame txd=%0d level=%0d ready=%0d", out_txd, out_fifo_level, out_ready);
    check("midrst_txd",   int'(out_txd),        1);
    check("midrst_busy",  int'(out_busy),       0);
    check("midrst_level", int'(out_fifo_level), 0);
    check("midrst_ready", int'(out_ready),      1);
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge in_clk); #1;
      if (out_busy) cnt++;
    end
    check("post_rst_busy_cycles", cnt, 0);

    // Divisor 0 selects the default (10), divisor 1 behaves as 2
    in_cfg_div = 0;
    push_burst(1, 8'h55);
    measure(10, -1, 0, -1, 0, wc, len, bits);
    $display("frame 8N1 word=55 div=0 busy_cycles=%0d bits=%b", len, bits[9:0]);
    check("div0_len", len, 100);
    check("div0_bits", int'(bits[9:0]), int'(10'b1010101010));
    in_cfg_div = 1;
    push_burst(1, 8'hC3);
    measure(2, -1, 0, -1, 0, wc, len, bits);
    $display("frame 8N1 word=c3 div=1 busy_cycles=%0d bits=%b", len, bits[9:0]);
    check("div1_len", len, 20);
    check("div1_bits", int'(bits[9:0]), int'(10'b1110000110));

    repeat (3) @(posedge in_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable, buffered UART transmitter that supersedes the fixed-format 8N1 transmitter in the serial I/O path. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Each frame has a start bit, 5–9 data bits, an optional even/odd parity bit, and 1 or 2 stop bits. Bit period is an exact clock-cycle divisor. Frames are sent back-to-back while the FIFO holds data.

## Interface
Parameters:
- CLK_RATE_MHz, 100: clock frequency; used only for the default divisor.
- BAUDRATE, 9600: default baud; DEF_DIV = CLK_RATE_MHz*1000000/BAUDRATE.
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4: words buffered; power of two, ≥2.
- DIV_WIDTH, 16: width of the runtime divisor; DEF_DIV must fit.

Ports:
- in_clk  input  1  sole clock, rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_en  input  1  transmitter clock-enable; low freezes FSM and bit counter (FIFO push unaffected).
- in_cfg_div  input  DIV_WIDTH  clocks per bit; 0 selects DEF_DIV, 1 treated as 2.
- in_cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none.
- in_cfg_stop2  input  1  1 = two stop bits.
- in_valid  input  1  write request.
- in_data  input  DATA_WIDTH  word to send.
- out_ready  output  1  FIFO not full; push occurs on edge with in_valid && out_ready.
- out_txd  output  1  registered serial line, idle high.
- out_busy  output  1  frame in progress.
- out_fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: out_txd=1. If in_en and FIFO non-empty: pop word, latch word, divisor, parity mode, stop count. Set out_txd<=0, clear bit counter. Go to START.
- Each bit state lasts exactly DIV enabled cycles; bit counter runs 0..DIV-1; advance on DIV-1.
- START→DATA: drive data[0]; DATA emits data[0..DATA_WIDTH-1] LSB-first.
- After the last data bit: go to PARITY if parity enabled, else STOP.
- Parity bit = ^data (even) or ~^data (odd).
- STOP holds out_txd=1 for 1 or 2 bit periods.
- At the end of STOP: if FIFO non-empty and in_en, pop and go to START directly (out_txd<=0, no idle cycle). Otherwise go to IDLE.
- Config inputs are sampled only at pop; changes mid-frame take effect on the next frame.
- out_busy = (state != IDLE).
- FIFO: synchronous, push/pop in same cycle allowed when not full/empty. Level is updated accordingly.
- out_ready = !full, independent of same-cycle pop, so a push is refused when full even if a pop occurs.
- Push while full is ignored; level and contents are unchanged.

## Timing
- Reset (async assert, sync-safe deassert), all state cleared:
  - out_txd=1, out_busy=0, out_ready=1, out_fifo_level=0.
  - FIFO pointers 0, FSM IDLE.
- Reset mid-frame aborts the frame immediately: line returns high, FIFO is flushed.
- Latency: push on edge N into an empty FIFO while IDLE with in_en=1 → pop on edge N+1, out_txd low after N+1.
- Frame length = (1 + DATA_WIDTH + P + S)·DIV enabled cycles (P∈{0,1}, S∈{1,2}).
- in_en low holds out_txd and all counters; the bit period stretches by the number of disabled cycles.
- out_fifo_level is registered and valid the cycle after each push/pop edge.

## Structure
- Shared package uart_pkg:
  - state encoding (3 bits);
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - default-divisor function.
  - The future uart_rx_cfg reuses the package.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; outputs full, empty, level), instantiated once.
- Top holds FSM, bit-period counter, shift register, parity accumulator.

## Test plan
- 8N1, in_cfg_div=16, push 0xA5:
  - out_txd = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles.
  - out_busy high for exactly 160 cycles.
- 8E2 and 8O1, div=16, push 0x07:
  - even: parity bit 1, frame 192 cycles;
  - odd: parity bit 0, frame 176 cycles.
- in_en=0, push 5 words:
  - 4 accepted, out_ready low after the 4th, level=4.
  - Raise in_en → four frames back-to-back, out_busy never drops, no idle cycle between stop and start.
- Change in_cfg_div 16→8 mid-frame: current frame keeps 16-cycle bits; next frame uses 8.
- Assert in_rst_n low during DATA bit 3 with 2 words queued:
  - out_txd=1 immediately, level=0, out_ready=1.
  - No further frames after release.
- in_cfg_div=0 with CLK_RATE_MHz=1, BAUDRATE=100000: bit period 10 cycles; in_cfg_div=1: bit period 2 cycles.
